// File: rtl/hazard_unit.sv
// Hazard detection, forwarding select and stall/flush sequencing for the 5-stage core.
// All control outputs are combinational from the current state and this cycle's inputs.
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReadE,
  input  logic             MemReadM,
  input  logic [1:0]       BranchD,
  input  logic             JumpSrcD,
  input  logic             DivE,
  input  logic             DivDoneE,
  input  logic             InstStall,
  input  logic             DataStall,
  input  logic             ExceptM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2,
    EXC_PEND = 2'd3
  } stateT;

  stateT stateReg, stateNext;
  logic [CNT_W-1:0] stallCntReg;

  // $zero is never a real producer, so it never matches.
  function automatic logic regMatch(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  // Operand 0 is Rs, operand 1 is Rt.
  logic [1:0][REG_W-1:0] srcE;
  logic [1:0][REG_W-1:0] srcD;
  logic [1:0][1:0]       fwdE;
  logic [1:0]            fwdD;
  logic [1:0]            hitE;
  logic [1:0]            hitM;

  assign srcE = {RtE, RsE};
  assign srcD = {RtD, RsD};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign fwdE[gi] = (RegWriteM && regMatch(WriteRegM, srcE[gi])) ? 2'b10 :
                        (RegWriteW && regMatch(WriteRegW, srcE[gi])) ? 2'b01 : 2'b00;
      assign fwdD[gi] = RegWriteM && regMatch(WriteRegM, srcD[gi]);
      // Producers a branch/jr in ID cannot yet see: ALU result in EX, load in MEM.
      assign hitE[gi] = RegWriteE && regMatch(WriteRegE, srcD[gi]);
      assign hitM[gi] = MemReadM && regMatch(WriteRegM, srcD[gi]);
    end
  endgenerate

  logic memStall, divStall, lwStall, brStall, useRt, isBranch;

  assign memStall = InstStall | DataStall;
  assign divStall = DivE & ~DivDoneE;
  assign lwStall  = MemReadE & RegWriteE & (hitE[0] | hitE[1]);
  assign isBranch = |BranchD;
  // A jump-register only reads Rs; conditional branches compare both operands.
  assign useRt    = isBranch;
  assign brStall  = (isBranch | JumpSrcD) &
                    (hitE[0] | hitM[0] | (useRt & (hitE[1] | hitM[1])));

  logic stallF, stallD, stallE, stallM, stallW;
  logic flushD, flushE, flushM, flushW;
  logic divBubble;

  // In DIV_WAIT the bubble lasts until the divider reports done, even if DivE drops.
  assign divBubble = (stateReg == DIV_WAIT) ? ~DivDoneE : divStall;

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (stateReg == EXC_PEND && !memStall) begin
      {flushD, flushE, flushM, flushW} = 4'b1111;
    end else if (memStall) begin
      {stallF, stallD, stallE, stallM, stallW} = 5'b11111;
    end else if (ExceptM) begin
      {flushD, flushE, flushM, flushW} = 4'b1111;
    end else if (divBubble) begin
      {stallF, stallD, stallE} = 3'b111;
      flushM = 1'b1;
    end else if (lwStall || brStall) begin
      {stallF, stallD} = 2'b11;
      flushE = 1'b1;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      EXC_PEND: begin
        if (!memStall) stateNext = RUN;
      end
      DIV_WAIT: begin
        if (memStall && ExceptM)  stateNext = EXC_PEND;
        else if (ExceptM)         stateNext = RUN;
        else if (DivDoneE)        stateNext = RUN;
      end
      default: begin
        // RUN and MEM_WAIT share the same exits; MEM_WAIT just marks a held pipeline.
        if (memStall && ExceptM)  stateNext = EXC_PEND;
        else if (memStall)        stateNext = MEM_WAIT;
        else if (ExceptM)         stateNext = RUN;
        else if (divStall)        stateNext = DIV_WAIT;
        else                      stateNext = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= RUN;
      stallCntReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (stallD && (stallCntReg != {CNT_W{1'b1}}))
        stallCntReg <= stallCntReg + CNT_W'(1);
    end
  end

  // Reset forces every control output low regardless of the inputs.
  assign StallF    = ~rst & stallF;
  assign StallD    = ~rst & stallD;
  assign StallE    = ~rst & stallE;
  assign StallM    = ~rst & stallM;
  assign StallW    = ~rst & stallW;
  assign FlushD    = ~rst & flushD;
  assign FlushE    = ~rst & flushE;
  assign FlushM    = ~rst & flushM;
  assign FlushW    = ~rst & flushW;
  assign ForwardAE = rst ? 2'b00 : fwdE[0];
  assign ForwardBE = rst ? 2'b00 : fwdE[1];
  assign ForwardAD = ~rst & fwdD[0];
  assign ForwardBD = ~rst & fwdD[1];
  assign StallCnt  = stallCntReg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; stall counter built narrow so saturation is reachable.
module tb_hazard_unit;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] LDUSE = 9'b110000100;
  localparam logic [8:0] DIVB  = 9'b111000010;
  localparam logic [8:0] HOLD  = 9'b111110000;
  localparam logic [8:0] FLUSH = 9'b000001111;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM;
  logic [1:0] BranchD;
  logic JumpSrcD, DivE, DivDoneE, InstStall, DataStall, ExceptM;
  logic StallF, StallD, StallE, StallM, StallW;
  logic FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD;
  logic [CNT_W-1:0] StallCnt;
  logic [8:0] ctrl;

  int passCnt = 0;
  int checkCnt = 0;
  int expCnt = 0;

  always #5 clk = ~clk;

  assign ctrl = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW};

  hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .MemReadM(MemReadM),
    .BranchD(BranchD), .JumpSrcD(JumpSrcD),
    .DivE(DivE), .DivDoneE(DivDoneE),
    .InstStall(InstStall), .DataStall(DataStall), .ExceptM(ExceptM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallCnt(StallCnt)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) begin
      passCnt++;
      $display("ok   %-12s = %0h", tag, got);
    end else begin
      $display("FAIL %-12s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearIn();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemReadE = 1'b0; MemReadM = 1'b0;
    BranchD = 2'b00; JumpSrcD = 1'b0;
    DivE = 1'b0; DivDoneE = 1'b0;
    InstStall = 1'b0; DataStall = 1'b0; ExceptM = 1'b0;
  endtask

  // Inputs are set at a falling edge; outputs checked 1 time unit later, then advance one cycle.
  task automatic stepCheck(input string tag, input logic [8:0] exp);
    #1;
    checkVal(tag, 32'(ctrl), 32'(exp));
    if (exp[7] && expCnt < 15) expCnt++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clearIn();
    // Inputs that would otherwise stall, flush and forward must be masked by reset.
    DivE = 1'b1; ExceptM = 1'b1; DataStall = 1'b1;
    RegWriteM = 1'b1; WriteRegM = 5'd3; RsE = 5'd3; RsD = 5'd3;
    #2;
    checkVal("rst_ctrl", 32'(ctrl), 32'(NONE));
    checkVal("rst_fwdAE", 32'(ForwardAE), 32'd0);
    checkVal("rst_fwdAD", 32'(ForwardAD), 32'd0);
    checkVal("rst_cnt", 32'(StallCnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearIn();
    stepCheck("idle", NONE);

    // Load-use hazards.
    MemReadE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
    stepCheck("lw_rs", LDUSE);
    clearIn();
    stepCheck("lw_clear", NONE);
    checkVal("cnt_lw", 32'(StallCnt), 32'(expCnt));
    MemReadE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RtD = 5'd8;
    stepCheck("lw_rt", LDUSE);
    RegWriteE = 1'b0;
    stepCheck("lw_nowr", NONE);
    RegWriteE = 1'b1; WriteRegE = 5'd0; RtD = 5'd0;
    stepCheck("lw_zero", NONE);

    // Forwarding selection.
    clearIn();
    RegWriteM = 1'b1; WriteRegM = 5'd9; RegWriteW = 1'b1; WriteRegW = 5'd9;
    RsE = 5'd9; RtE = 5'd9; RsD = 5'd9;
    #1;
    checkVal("fwdAE_mem", 32'(ForwardAE), 32'd2);
    checkVal("fwdBE_mem", 32'(ForwardBE), 32'd2);
    checkVal("fwdAD_mem", 32'(ForwardAD), 32'd1);
    checkVal("fwdBD_none", 32'(ForwardBD), 32'd0);
    @(negedge clk);
    WriteRegM = 5'd0;
    #1;
    checkVal("fwdAE_wb", 32'(ForwardAE), 32'd1);
    checkVal("fwdAD_m0", 32'(ForwardAD), 32'd0);
    @(negedge clk);
    RegWriteW = 1'b0;
    #1;
    checkVal("fwdAE_none", 32'(ForwardAE), 32'd0);
    @(negedge clk);
    RegWriteW = 1'b1; WriteRegW = 5'd0; RsE = 5'd0; RtE = 5'd5;
    RegWriteM = 1'b1; WriteRegM = 5'd5; RtD = 5'd5;
    #1;
    checkVal("fwdAE_zero", 32'(ForwardAE), 32'd0);
    checkVal("fwdBE_mem2", 32'(ForwardBE), 32'd2);
    checkVal("fwdBD_mem", 32'(ForwardBD), 32'd1);
    @(negedge clk);

    // Branch / jump-register operand hazards.
    clearIn();
    BranchD = 2'b01; RsD = 5'd4; RegWriteE = 1'b1; WriteRegE = 5'd4;
    stepCheck("br_exrs", LDUSE);
    WriteRegE = 5'd0;
    stepCheck("br_zero", NONE);
    BranchD = 2'b00; JumpSrcD = 1'b1; RsD = 5'd0; RtD = 5'd4; WriteRegE = 5'd4;
    stepCheck("jr_rt_ign", NONE);
    RsD = 5'd4;
    stepCheck("jr_rs", LDUSE);
    clearIn();
    BranchD = 2'b10; MemReadM = 1'b1; WriteRegM = 5'd5; RtD = 5'd5;
    stepCheck("br_memld", LDUSE);
    clearIn();
    stepCheck("br_clear", NONE);
    checkVal("cnt_br", 32'(StallCnt), 32'(expCnt));

    // Multi-cycle divide: 32 bubble cycles, then a clean release.
    DivE = 1'b1;
    for (int i = 0; i < 32; i++) stepCheck($sformatf("div_%0d", i), DIVB);
    DivDoneE = 1'b1;
    stepCheck("div_done", NONE);
    clearIn();
    stepCheck("div_after", NONE);
    checkVal("cnt_sat", 32'(StallCnt), 32'(expCnt));

    // Memory wait with an exception arriving under it: flush deferred until memory ready.
    DataStall = 1'b1; ExceptM = 1'b1;
    stepCheck("mem_exc_1", HOLD);
    ExceptM = 1'b0;
    stepCheck("mem_exc_2", HOLD);
    stepCheck("mem_exc_3", HOLD);
    DataStall = 1'b0;
    stepCheck("exc_flush", FLUSH);
    stepCheck("exc_after", NONE);

    // Exception overrides a simultaneous load-use hazard.
    ExceptM = 1'b1; MemReadE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
    stepCheck("exc_over_lw", FLUSH);
    clearIn();
    InstStall = 1'b1;
    stepCheck("istall", HOLD);
    InstStall = 1'b0;
    stepCheck("istall_rel", NONE);

    // Reset in the middle of a divide wait.
    DivE = 1'b1;
    stepCheck("div_pre_rst0", DIVB);
    stepCheck("div_pre_rst1", DIVB);
    rst = 1'b1;
    expCnt = 0;
    #1;
    checkVal("rst_div_ctrl", 32'(ctrl), 32'(NONE));
    checkVal("rst_div_cnt", 32'(StallCnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    DivE = 1'b0;
    stepCheck("post_rst_run", NONE);
    checkVal("post_rst_cnt", 32'(StallCnt), 32'(expCnt));

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
